parity_frame_stats: RTL

Downstream consumer of the even/odd classifier. Takes a stream of single-bit is-even flags and groups them into frames. For each frame it accumulates even/odd counts and the longest run of consecutive evens. It then presents a per-frame summary to the next stage over a valid/ready handshake, holding the summary until that stage accepts it.

---
 rtl/parity_frame_stats.sv | 112 +++++++++++
 1 files changed

// File: rtl/parity_frame_stats.sv
// Groups a stream of is-even flags into frames and reports per-frame even/odd
// counts and the longest run of evens over a valid/ready handshake.
module parity_frame_stats #(
  parameter int FRAME_LEN = 16,
  parameter int RUN_LEN   = 4,
  localparam int CW       = $clog2(FRAME_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_is_even,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] sample_count,
  output logic [CW-1:0] even_count,
  output logic [CW-1:0] odd_count,
  output logic [CW-1:0] max_run,
  output logic          run_hit
);

  typedef enum logic {COLLECT = 1'b0, REPORT = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] evens_q, evens_d;
  logic [CW-1:0] cur_run_q, cur_run_d;
  logic [CW-1:0] best_run_q, best_run_d;
  logic [CW-1:0] sample_count_q, sample_count_d;
  logic [CW-1:0] even_count_q, even_count_d;
  logic [CW-1:0] odd_count_q, odd_count_d;
  logic [CW-1:0] max_run_q, max_run_d;
  logic          run_hit_q, run_hit_d;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    evens_d        = evens_q;
    cur_run_d      = cur_run_q;
    best_run_d     = best_run_q;
    sample_count_d = sample_count_q;
    even_count_d   = even_count_q;
    odd_count_d    = odd_count_q;
    max_run_d      = max_run_q;
    run_hit_d      = run_hit_q;
    unique case (state_q)
      COLLECT: begin
        if (in_valid) begin
          cnt_d      = cnt_q + CW'(1);
          evens_d    = evens_q + CW'(in_is_even);
          cur_run_d  = in_is_even ? cur_run_q + CW'(1) : '0;
          best_run_d = (cur_run_d > best_run_q) ? cur_run_d : best_run_q;
          // Summary captures the counters as updated by the closing sample.
          if (in_last || (cnt_q == CW'(FRAME_LEN - 1))) begin
            sample_count_d = cnt_d;
            even_count_d   = evens_d;
            odd_count_d    = cnt_d - evens_d;
            max_run_d      = best_run_d;
            run_hit_d      = (best_run_d >= CW'(RUN_LEN));
            state_d        = REPORT;
          end
        end
      end
      REPORT: begin
        if (out_ready) begin
          cnt_d      = '0;
          evens_d    = '0;
          cur_run_d  = '0;
          best_run_d = '0;
          state_d    = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= COLLECT;
      cnt_q          <= '0;
      evens_q        <= '0;
      cur_run_q      <= '0;
      best_run_q     <= '0;
      sample_count_q <= '0;
      even_count_q   <= '0;
      odd_count_q    <= '0;
      max_run_q      <= '0;
      run_hit_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      evens_q        <= evens_d;
      cur_run_q      <= cur_run_d;
      best_run_q     <= best_run_d;
      sample_count_q <= sample_count_d;
      even_count_q   <= even_count_d;
      odd_count_q    <= odd_count_d;
      max_run_q      <= max_run_d;
      run_hit_q      <= run_hit_d;
    end
  end

  assign in_ready     = (state_q == COLLECT);
  assign out_valid    = (state_q == REPORT);
  assign sample_count = sample_count_q;
  assign even_count   = even_count_q;
  assign odd_count    = odd_count_q;
  assign max_run      = max_run_q;
  assign run_hit      = run_hit_q;

endmodule
